// File: rtl/boot_sequencer.sv
// boot_sequencer: load a data image into DMem, pulse the core out of reset,
// wait for done or a cycle timeout, then stream a result window back out.
module boot_sequencer #(
    parameter logic [7:0] DUMP_BASE  = 8'd0,
    parameter int         DUMP_LEN   = 8,
    parameter int         RST_CYCLES = 2,
    parameter int         TIMEOUT    = 4095,
    parameter int         CYCW       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_addr,
    input  logic [7:0]      in_data,
    input  logic            in_last,
    output logic            dm_wen,
    output logic [7:0]      dm_addr,
    output logic [7:0]      dm_wdat,
    input  logic [7:0]      dm_rdat,
    output logic            core_reset,
    input  logic            core_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_last,
    output logic            busy,
    output logic            timeout,
    output logic [CYCW-1:0] cycles
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RST_CORE = 3'd2,
        ST_RUN      = 3'd3,
        ST_DUMP     = 3'd4,
        ST_FINISH   = 3'd5
    } state_t;

    localparam logic [CYCW-1:0] CYC_MAX   = {CYCW{1'b1}};
    localparam logic [CYCW-1:0] TIMEOUT_C = CYCW'(TIMEOUT);
    localparam logic [8:0]      LEN_C     = 9'(DUMP_LEN);
    localparam logic [8:0]      LAST_IDX  = 9'(DUMP_LEN - 1);
    localparam logic [15:0]     RST_LAST  = 16'(RST_CYCLES - 1);

    state_t          state_r, state_s;
    logic [15:0]     rst_cnt_r, rst_cnt_s;
    logic [CYCW-1:0] cycles_r, cycles_s, cyc_inc_s;
    logic            timeout_r, timeout_s;
    logic [8:0]      idx_r, idx_s;
    logic            out_valid_r, out_valid_s;
    logic [7:0]      out_data_r, out_data_s;
    logic            out_last_r, out_last_s;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: reset-hold counter, run counter, dump index, output slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt_r   <= 16'd0;
            cycles_r    <= {CYCW{1'b0}};
            timeout_r   <= 1'b0;
            idx_r       <= 9'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_last_r  <= 1'b0;
        end else begin
            rst_cnt_r   <= rst_cnt_s;
            cycles_r    <= cycles_s;
            timeout_r   <= timeout_s;
            idx_r       <= idx_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_last_r  <= out_last_s;
        end
    end

    // Next-state, next-datapath and the combinational DMem port
    always_comb begin
        state_s     = state_r;
        rst_cnt_s   = rst_cnt_r;
        cycles_s    = cycles_r;
        timeout_s   = timeout_r;
        idx_s       = idx_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_last_s  = out_last_r;
        dm_wen      = 1'b0;
        dm_addr     = 8'd0;
        dm_wdat     = 8'd0;
        // saturating increment so a huge TIMEOUT can never wrap the counter
        if (cycles_r == CYC_MAX) begin
            cyc_inc_s = cycles_r;
        end else begin
            cyc_inc_s = cycles_r + {{(CYCW-1){1'b0}}, 1'b1};
        end

        case (state_r)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_s   = ST_LOAD;
                    cycles_s  = {CYCW{1'b0}};
                    timeout_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                // in_ready is 1 throughout LOAD, so in_valid alone is the handshake
                if (in_valid) begin
                    dm_wen  = 1'b1;
                    dm_addr = in_addr;
                    dm_wdat = in_data;
                    if (in_last) begin
                        state_s   = ST_RST_CORE;
                        rst_cnt_s = 16'd0;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RST_CORE: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    rst_cnt_s = rst_cnt_r + 16'd1;
                end
            end
            ST_RUN: begin
                cycles_s = cyc_inc_s;
                // done has priority over a timeout on the same cycle
                if (core_done) begin
                    state_s = ST_DUMP;
                    idx_s   = 9'd0;
                end else if (cyc_inc_s >= TIMEOUT_C) begin
                    state_s   = ST_DUMP;
                    timeout_s = 1'b1;
                    idx_s     = 9'd0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DUMP: begin
                dm_addr = DUMP_BASE + idx_r[7:0];
                if (out_valid_r && out_ready && out_last_r) begin
                    state_s     = ST_FINISH;
                    out_valid_s = 1'b0;
                    out_last_s  = 1'b0;
                end else if ((!out_valid_r || out_ready) && (idx_r < LEN_C)) begin
                    out_data_s  = dm_rdat;
                    out_valid_s = 1'b1;
                    out_last_s  = (idx_r == LAST_IDX);
                    idx_s       = idx_r + 9'd1;
                end else begin
                    state_s = ST_DUMP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = (state_r == ST_LOAD);
    assign busy       = (state_r != ST_IDLE) && (state_r != ST_FINISH);
    assign core_reset = (state_r != ST_RUN);
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign timeout    = timeout_r;
    assign cycles     = cycles_r;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: randomized loads, run lengths and
// output back-pressure checked against a memory-image model.
module tb_boot_sequencer;

    localparam logic [7:0] BASE = 8'hFE;
    localparam int LEN  = 4;
    localparam int RSTC = 2;
    localparam int TMO  = 15;
    localparam int CYCW = 16;

    logic            clk, reset, start;
    logic            in_valid, in_ready, in_last;
    logic [7:0]      in_addr, in_data;
    logic            dm_wen;
    logic [7:0]      dm_addr, dm_wdat, dm_rdat;
    logic            core_reset, core_done;
    logic            out_valid, out_ready, out_last;
    logic [7:0]      out_data;
    logic            busy, timeout;
    logic [CYCW-1:0] cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] ld_addr [16];
    logic [7:0] ld_data [16];
    int         ld_n;

    boot_sequencer #(.DUMP_BASE(BASE), .DUMP_LEN(LEN), .RST_CYCLES(RSTC),
                     .TIMEOUT(TMO), .CYCW(CYCW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_last(in_last),
        .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdat(dm_wdat), .dm_rdat(dm_rdat),
        .core_reset(core_reset), .core_done(core_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .timeout(timeout), .cycles(cycles)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMem model: combinational read, write on the rising edge
    assign dm_rdat = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_wen) mem[dm_addr] <= dm_wdat;
    end

    // Hard stop in case something never terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_addr = 8'd0; in_data = 8'd0;
        in_last = 1'b0; core_done = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({in_ready, dm_wen, dm_addr, dm_wdat, core_reset, out_valid, out_data,
             out_last, busy, timeout, cycles} !== {1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0,
             8'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b wen=%b addr=%h wdat=%h crst=%b ov=%b od=%h ol=%b busy=%b to=%b cyc=%0d exp all 0 except crst=1",
                     in_ready, dm_wen, dm_addr, dm_wdat, core_reset, out_valid, out_data,
                     out_last, busy, timeout, cycles);
        end
        reset = 1'b1;
        tick();
    endtask

    // One complete start/load/run/dump sequence; abort_at>0 pulls reset in that RUN cycle
    task automatic run_seq(input string name, input int done_at, input int ready_mode,
                           input int abort_at);
        int exp_cyc;
        bit exp_to;
        int got;
        int dump_cyc;
        bit rdy;
        bit was_stall;
        logic [7:0] held;
        logic [7:0] exp_byte;
        logic [3:0] pat;
        pat = 4'b1001;
        if (done_at <= TMO) begin exp_cyc = done_at; exp_to = 1'b0; end
        else begin exp_cyc = TMO; exp_to = 1'b1; end

        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if ({in_ready, busy, timeout, cycles} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL %s start: rdy=%b busy=%b to=%b cyc=%0d exp 1 1 0 0",
                     name, in_ready, busy, timeout, cycles);
        end

        for (int i = 0; i < ld_n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                n_checks++;
                if (dm_wen !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s load_gap_wen: got %b exp 0", name, dm_wen);
                end
                tick();
            end
            in_valid = 1'b1; in_addr = ld_addr[i]; in_data = ld_data[i];
            in_last = (i == ld_n - 1);
            @(negedge clk);
            n_checks++;
            if ({dm_wen, dm_addr, dm_wdat} !== {1'b1, ld_addr[i], ld_data[i]}) begin
                n_fail++;
                $display("FAIL %s load_write: wen=%b addr=%h data=%h exp 1 %h %h",
                         name, dm_wen, dm_addr, dm_wdat, ld_addr[i], ld_data[i]);
            end
            tick();
            exp_mem[ld_addr[i]] = ld_data[i];
            in_valid = 1'b0; in_last = 1'b0;
        end

        // done high while the core is held in reset must be ignored
        core_done = 1'b1;
        for (int c = 0; c < RSTC; c++) begin
            n_checks++;
            if ({core_reset, busy, in_ready} !== 3'b110) begin
                n_fail++;
                $display("FAIL %s rst_hold%0d: crst=%b busy=%b rdy=%b exp 1 1 0",
                         name, c, core_reset, busy, in_ready);
            end
            tick();
        end

        for (int k = 1; k <= exp_cyc; k++) begin
            n_checks++;
            if ({core_reset, busy, cycles} !== {1'b0, 1'b1, 16'(k - 1)}) begin
                n_fail++;
                $display("FAIL %s run%0d: crst=%b busy=%b cyc=%0d exp 0 1 %0d",
                         name, k, core_reset, busy, cycles, k - 1);
            end
            core_done = (k == done_at);
            start = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_addr = BASE; in_data = 8'($urandom); in_last = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dm_wen !== 1'b0) begin
                n_fail++;
                $display("FAIL %s run_wen%0d: got %b exp 0", name, k, dm_wen);
            end
            if (k == abort_at) begin
                #1 reset = 1'b0;
                #1;
                n_checks++;
                if ({in_ready, dm_wen, dm_addr, core_reset, out_valid, busy, timeout, cycles}
                    !== {1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
                    n_fail++;
                    $display("FAIL %s abort: rdy=%b wen=%b addr=%h crst=%b ov=%b busy=%b to=%b cyc=%0d exp 0 0 00 1 0 0 0 0",
                             name, in_ready, dm_wen, dm_addr, core_reset, out_valid, busy,
                             timeout, cycles);
                end
                start = 1'b0; in_valid = 1'b0; in_last = 1'b0; core_done = 1'b0;
                tick();
                reset = 1'b1;
                tick();
                return;
            end
            tick();
        end
        core_done = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;

        n_checks++;
        if ({core_reset, out_valid, busy, timeout, cycles} !==
            {1'b1, 1'b0, 1'b1, exp_to, 16'(exp_cyc)}) begin
            n_fail++;
            $display("FAIL %s dump_entry: crst=%b ov=%b busy=%b to=%b cyc=%0d exp 1 0 1 %b %0d",
                     name, core_reset, out_valid, busy, timeout, cycles, exp_to, exp_cyc);
        end

        got = 0; dump_cyc = 0; was_stall = 1'b0; held = 8'd0;
        while (got < LEN && dump_cyc < 100) begin
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[3 - (dump_cyc % 4)];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (out_valid) begin
                exp_byte = exp_mem[8'(BASE + got)];
                n_checks++;
                if ({out_data, out_last} !== {exp_byte, 1'(got == LEN - 1)}) begin
                    n_fail++;
                    $display("FAIL %s dump_byte%0d: data=%h last=%b exp %h %b",
                             name, got, out_data, out_last, exp_byte, (got == LEN - 1));
                end
                if (was_stall) begin
                    n_checks++;
                    if (out_data !== held) begin
                        n_fail++;
                        $display("FAIL %s stall_hold: got %h exp %h", name, out_data, held);
                    end
                end
                held = out_data;
                was_stall = !rdy;
                if (rdy) got++;
            end else if (got > 0 || dump_cyc > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s dump_valid: out_valid dropped at dump cycle %0d exp 1",
                         name, dump_cyc);
            end
            dump_cyc++;
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (got != LEN) begin
            n_fail++;
            $display("FAIL %s dump_count: got %0d bytes exp %0d", name, got, LEN);
        end
        if (ready_mode == 0) begin
            n_checks++;
            if (dump_cyc != LEN + 1) begin
                n_fail++;
                $display("FAIL %s throughput: got %0d cycles exp %0d", name, dump_cyc, LEN + 1);
            end
        end

        repeat (3) begin
            n_checks++;
            if ({out_valid, busy, core_reset, in_ready, timeout, cycles} !==
                {1'b0, 1'b0, 1'b1, 1'b0, exp_to, 16'(exp_cyc)}) begin
                n_fail++;
                $display("FAIL %s finish: ov=%b busy=%b crst=%b rdy=%b to=%b cyc=%0d exp 0 0 1 0 %b %0d",
                         name, out_valid, busy, core_reset, in_ready, timeout, cycles,
                         exp_to, exp_cyc);
            end
            tick();
        end
    endtask

    task automatic test_wrap_dump();
        ld_n = 4;
        for (int i = 0; i < 4; i++) begin
            ld_addr[i] = 8'(BASE + i);
            ld_data[i] = 8'($urandom);
        end
        run_seq("wrap", 20, 0, 0);
    endtask

    task automatic test_load_gaps();
        ld_n = 3;
        ld_addr[0] = 8'h10; ld_data[0] = 8'hAA;
        ld_addr[1] = 8'h11; ld_data[1] = 8'hBB;
        ld_addr[2] = 8'h12; ld_data[2] = 8'hCC;
        run_seq("gaps", 7, 0, 0);
    endtask

    task automatic test_timeout();
        ld_n = 2;
        ld_addr[0] = 8'hFF; ld_data[0] = 8'($urandom);
        ld_addr[1] = 8'h00; ld_data[1] = 8'($urandom);
        run_seq("timeout", 1000, 0, 0);
    endtask

    task automatic test_done_vs_timeout();
        ld_n = 1;
        ld_addr[0] = 8'h01; ld_data[0] = 8'($urandom);
        run_seq("tie", TMO, 0, 0);
    endtask

    task automatic test_stall();
        ld_n = 2;
        ld_addr[0] = 8'hFE; ld_data[0] = 8'($urandom);
        ld_addr[1] = 8'h00; ld_data[1] = 8'($urandom);
        run_seq("stall", 5, 1, 0);
    endtask

    task automatic test_reset_mid_run();
        ld_n = 1;
        ld_addr[0] = 8'hFF; ld_data[0] = 8'($urandom);
        run_seq("abort", 10, 0, 6);
        ld_addr[0] = 8'h00; ld_data[0] = 8'($urandom);
        run_seq("after_abort", 3, 2, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            ld_n = $urandom_range(1, 6);
            for (int i = 0; i < ld_n; i++) begin
                ld_addr[i] = 8'(BASE + $urandom_range(0, 5));
                ld_data[i] = 8'($urandom);
            end
            run_seq("random", $urandom_range(1, TMO + 3), $urandom_range(0, 2), 0);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'd0;
        ld_n = 0;
        test_reset();
        test_wrap_dump();
        test_load_gaps();
        test_timeout();
        test_done_vs_timeout();
        test_stall();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Sequences one processor run, sitting directly around the processor top.
- Streams a program-data image into data memory, then holds the core in reset for a fixed time and releases it.
- Waits for the core's done flag or a cycle timeout, then reads a result window back out of data memory over a valid/ready stream.
- Owns the DMem write port while loading and the DMem read address while dumping.

Parameters:
- DUMP_BASE, 0: first DMem address of the result window.
- DUMP_LEN, 8: number of result bytes to stream out (1..256).
- RST_CYCLES, 2: number of cycles core_reset is held high before release (>=1).
- TIMEOUT, 4095: maximum number of RUN cycles before the run is aborted.
- CYCW, 16: width of the cycle counter; must satisfy TIMEOUT < 2^CYCW.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  begin a load/run/dump sequence; honoured only in IDLE or FINISH
- in_valid  in  1  load byte valid
- in_ready  out  1  load byte accepted
- in_addr  in  8  DMem address of load byte
- in_data  in  8  load byte value
- in_last  in  1  marks the final load byte
- dm_wen  out  1  DMem write enable
- dm_addr  out  8  DMem address
- dm_wdat  out  8  DMem write data
- dm_rdat  in  8  DMem read data, combinational from dm_addr
- core_reset  out  1  active-high reset to the core
- core_done  in  1  core finished flag
- out_valid  out  1  result byte valid
- out_ready  in  1  result byte consumed
- out_data  out  8  result byte
- out_last  out  1  final result byte
- busy  out  1  high in every state except IDLE and FINISH
- timeout  out  1  sticky flag: the last run hit TIMEOUT
- cycles  out  CYCW  number of RUN cycles in the last run

Behaviour:
- Reset values: state=IDLE, in_ready=0, dm_wen=0, dm_addr=0, dm_wdat=0, core_reset=1, out_valid=0, out_data=0, out_last=0, busy=0, timeout=0, cycles=0.
- Reset mid-operation returns to these values immediately. The core is held in reset.
- States and transitions:
  - IDLE/FINISH + start -> LOAD. Clears timeout and cycles. start is ignored in all other states.
  - LOAD:
    - in_ready=1.
    - On in_valid&in_ready, combinationally drive dm_wen=1, dm_addr=in_addr, dm_wdat=in_data; the write lands at that edge.
    - in_valid with in_ready=0 (any other state) is ignored and causes no write.
    - An accepted byte with in_last=1 -> RST_CORE.
  - RST_CORE:
    - core_reset=1 for exactly RST_CYCLES cycles, then -> RUN.
    - core_done is ignored in this state.
  - RUN:
    - core_reset=0.
    - cycles increments every RUN cycle, saturating at 2^CYCW-1.
    - core_done sampled high -> DUMP.
    - Otherwise, when cycles reaches TIMEOUT -> DUMP with timeout=1.
    - If done and timeout occur on the same cycle, done wins and timeout stays 0.
  - DUMP:
    - core_reset=1 (core frozen). dm_wen=0. dm_addr=(DUMP_BASE+idx) mod 256; idx starts at 0.
    - One-entry output register: when out_valid=0, or out_valid&out_ready, load out_data=dm_rdat, set out_valid=1, out_last=(idx==DUMP_LEN-1), then idx++.
    - The first out_valid rises 1 cycle after entering DUMP.
    - While out_valid&!out_ready, out_data and out_last are held stable.
    - Handshake on the out_last byte -> FINISH, and out_valid drops the next cycle.
  - FINISH:
    - busy=0. core_reset=1. timeout and cycles are held until the next start.
- Full throughput: with out_ready held at 1, one byte transfers per cycle.
- Address wrap: DUMP_BASE+idx wraps modulo 256 with no error.

Test Plan:
- Load 3 bytes {0x10:0xAA, 0x11:0xBB, 0x12:0xCC, last} with in_valid gaps -> exactly 3 dm_wen pulses with matching addr/data; core_reset stays high 2 cycles after last, then drops.
- core_done asserted 20 cycles after release, DUMP_BASE=0x10, DUMP_LEN=3, out_ready=1 -> out_data AA, BB, CC on consecutive cycles; out_last on CC; cycles=20; timeout=0; busy falls.
- TIMEOUT=15, core_done never asserted -> DUMP entered after 15 RUN cycles; timeout=1; cycles=15; dump still completes.
- out_ready toggled 1,0,0,1 during DUMP -> no byte lost or duplicated; out_data stable while stalled.
- DUMP_BASE=0xFE, DUMP_LEN=4 -> addresses FE, FF, 00, 01 in order.
- reset low during RUN, then start again -> all outputs at reset values, core_reset=1; second sequence runs normally with cycles restarting from 0.
